// File: rtl/tff_toggle_arbiter.sv
// Round-robin owner of one shared T flip-flop: grants one requester a burst of K toggles, then pulses done.
// Grant one cycle after req is seen in IDLE; bursts run to completion regardless of req; outputs purely registered-state decodes.
module tff_toggle_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*CNT_W-1:0]   cnt,
  output logic [N-1:0]         gnt,
  output logic                 busy,
  output logic                 t_en,
  output logic                 t,
  output logic                 q,
  output logic                 qb,
  output logic [N-1:0]         done
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_win;
  logic [CNT_W-1:0] r_rem;
  logic             r_q;

  logic             w_any;
  logic [PW-1:0]    w_sel;
  logic [CNT_W-1:0] w_sel_cnt;
  logic [N-1:0]     w_win_oh;

  // First asserted request at or after the pointer, wrapping modulo N.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_ptr;
    for (int i = 0; i < N; i++) begin
      if (!w_any && req[(int'(r_ptr) + i) % N]) begin
        w_any = 1'b1;
        w_sel = PW'((int'(r_ptr) + i) % N);
      end
    end
  end

  assign w_sel_cnt = cnt[int'(w_sel)*CNT_W +: CNT_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_win_oh    = N'(1) << r_win;
    gnt         = '0;
    done        = '0;
    busy        = 1'b0;
    t_en        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = (w_sel_cnt != '0) ? S_BURST : S_DONE;
        end
      end
      S_BURST: begin
        busy = 1'b1;
        t_en = 1'b1;
        gnt  = w_win_oh;
        if (r_rem <= CNT_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        gnt         = w_win_oh;
        done        = w_win_oh;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
      r_win <= '0;
      r_rem <= '0;
      r_q   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win <= w_sel;
            r_rem <= w_sel_cnt;
          end
        end
        S_BURST: begin
          r_q <= ~r_q;
          if (r_rem != '0) begin
            r_rem <= r_rem - 1'b1;
          end
        end
        S_DONE: begin
          r_ptr <= (r_win == PW'(N-1)) ? '0 : r_win + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign t  = t_en;
  assign q  = r_q;
  assign qb = ~r_q;

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Directed bench for tff_toggle_arbiter: reset, single burst, zero count, round-robin, mid-burst reset, fairness at max count.
module tb_tff_toggle_arbiter;

  localparam int N     = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*CNT_W-1:0] cnt;
  logic [N-1:0]     gnt;
  logic             busy;
  logic             t_en;
  logic             t;
  logic             q;
  logic             qb;
  logic [N-1:0]     done;

  int   checks   = 0;
  int   failures = 0;
  logic exp_q;

  tff_toggle_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .cnt  (cnt),
    .gnt  (gnt),
    .busy (busy),
    .t_en (t_en),
    .t    (t),
    .q    (q),
    .qb   (qb),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'($urandom);
    cnt = 16'($urandom);
    step();
    step();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done got=%b exp=0000", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (t_en !== 1'b0 || t !== 1'b0) begin failures++; $display("FAIL reset_ten got=%b/%b exp=0/0", t_en, t); end
    checks++; if (q !== 1'b0 || qb !== 1'b1) begin failures++; $display("FAIL reset_q got=%b/%b exp=0/1", q, qb); end
    req = '0;
    rst = 1'b1;
    step();
    step();
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle gnt=%b busy=%b exp 0000/0", gnt, busy); end
    checks++; if (t_en !== 1'b0 || done !== 4'b0000) begin failures++; $display("FAIL post_reset_ten t_en=%b done=%b exp 0/0000", t_en, done); end
    checks++; if (q !== 1'b0 || qb !== 1'b1) begin failures++; $display("FAIL post_reset_q got=%b/%b exp=0/1", q, qb); end
    exp_q = 1'b0;
  endtask

  task automatic test_single_burst();
    req = 4'b0001;
    cnt = 16'h0003;
    step();
    checks++; if (gnt !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL single_grant gnt=%b busy=%b exp 0001/1", gnt, busy); end
    // Drop req and zero cnt: the latched burst must still run 3 toggles.
    req = '0;
    cnt = '0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (t_en !== 1'b1 || t !== 1'b1) begin failures++; $display("FAIL single_ten k=%0d got=%b/%b exp=1/1", k, t_en, t); end
      checks++; if (q !== exp_q || done !== 4'b0000) begin failures++; $display("FAIL single_q k=%0d q=%b done=%b exp %b/0000", k, q, done, exp_q); end
      step();
      exp_q = ~exp_q;
    end
    checks++; if (done !== 4'b0001 || gnt !== 4'b0001) begin failures++; $display("FAIL single_done done=%b gnt=%b exp 0001/0001", done, gnt); end
    checks++; if (t_en !== 1'b0) begin failures++; $display("FAIL single_done_ten got=%b exp=0", t_en); end
    checks++; if (q !== 1'b1 || qb !== 1'b0) begin failures++; $display("FAIL single_final_q got=%b/%b exp=1/0", q, qb); end
    step();
    checks++; if (busy !== 1'b0 || gnt !== 4'b0000 || done !== 4'b0000) begin failures++; $display("FAIL single_idle busy=%b gnt=%b done=%b", busy, gnt, done); end
  endtask

  task automatic test_zero_count();
    req = 4'b1000;
    cnt = 16'h0FFF;
    step();
    checks++; if (gnt !== 4'b1000 || done !== 4'b1000) begin failures++; $display("FAIL zero_done gnt=%b done=%b exp 1000/1000", gnt, done); end
    checks++; if (t_en !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL zero_ten t_en=%b busy=%b exp 0/1", t_en, busy); end
    checks++; if (q !== exp_q) begin failures++; $display("FAIL zero_q got=%b exp=%b", q, exp_q); end
    req = '0;
    step();
    checks++; if (gnt !== 4'b0000 || done !== 4'b0000 || t_en !== 1'b0) begin failures++; $display("FAIL zero_idle gnt=%b done=%b t_en=%b", gnt, done, t_en); end
    checks++; if (q !== exp_q) begin failures++; $display("FAIL zero_q_after got=%b exp=%b", q, exp_q); end
  endtask

  task automatic test_round_robin();
    int       ord[4] = '{0, 2, 0, 2};
    int       kk[4]  = '{1, 2, 1, 2};
    logic [3:0] exp_oh;
    req = 4'b0101;
    cnt = 16'h0201;
    step();
    for (int g = 0; g < 4; g++) begin
      exp_oh = 4'b0001 << ord[g];
      checks++; if (gnt !== exp_oh) begin failures++; $display("FAIL rr_gnt g=%0d got=%b exp=%b", g, gnt, exp_oh); end
      for (int k = 0; k < kk[g]; k++) begin
        checks++; if (t_en !== 1'b1 || q !== exp_q) begin failures++; $display("FAIL rr_burst g=%0d k=%0d t_en=%b q=%b exp 1/%b", g, k, t_en, q, exp_q); end
        step();
        exp_q = ~exp_q;
      end
      checks++; if (done !== exp_oh || q !== exp_q) begin failures++; $display("FAIL rr_done g=%0d done=%b q=%b exp %b/%b", g, done, q, exp_oh, exp_q); end
      if (g == 3) req = '0;
      step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle g=%0d busy=%b exp=0", g, busy); end
      if (g < 3) step();
    end
  endtask

  task automatic test_reset_mid_burst();
    req = 4'b0010;
    cnt = 16'h00A0;
    step();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL mid_gnt got=%b exp=0010", gnt); end
    for (int k = 0; k < 4; k++) begin
      step();
      exp_q = ~exp_q;
    end
    checks++; if (q !== exp_q || t_en !== 1'b1) begin failures++; $display("FAIL mid_before q=%b t_en=%b exp %b/1", q, t_en, exp_q); end
    rst = 1'b0;
    #1;
    checks++; if (q !== 1'b0 || qb !== 1'b1 || gnt !== 4'b0000) begin failures++; $display("FAIL mid_async q=%b qb=%b gnt=%b exp 0/1/0000", q, qb, gnt); end
    checks++; if (busy !== 1'b0 || t_en !== 1'b0 || done !== 4'b0000) begin failures++; $display("FAIL mid_async_ctl busy=%b t_en=%b done=%b", busy, t_en, done); end
    step();
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL mid_no_done got=%b exp=0000", done); end
    rst = 1'b1;
    exp_q = 1'b0;
    step();
    checks++; if (gnt !== 4'b0010 || busy !== 1'b1) begin failures++; $display("FAIL mid_regrant gnt=%b busy=%b exp 0010/1", gnt, busy); end
    for (int k = 0; k < 10; k++) begin
      checks++; if (t_en !== 1'b1 || q !== exp_q || done !== 4'b0000) begin failures++; $display("FAIL mid_burst k=%0d t_en=%b q=%b done=%b exp q=%b", k, t_en, q, done, exp_q); end
      step();
      exp_q = ~exp_q;
    end
    checks++; if (done !== 4'b0010 || q !== 1'b0) begin failures++; $display("FAIL mid_done done=%b q=%b exp 0010/0", done, q); end
    req = '0;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_fairness_max();
    logic [3:0] exp_oh;
    int         n_ten;
    rst = 1'b0;
    step();
    rst = 1'b1;
    exp_q = 1'b0;
    req = 4'b1111;
    cnt = 16'hFFFF;
    step();
    for (int g = 0; g < 5; g++) begin
      exp_oh = 4'b0001 << (g % 4);
      checks++; if (gnt !== exp_oh) begin failures++; $display("FAIL fair_gnt g=%0d got=%b exp=%b", g, gnt, exp_oh); end
      n_ten = 0;
      for (int k = 0; k < 15; k++) begin
        if (t_en === 1'b1) n_ten++;
        checks++; if (q !== exp_q) begin failures++; $display("FAIL fair_q g=%0d k=%0d got=%b exp=%b", g, k, q, exp_q); end
        step();
        exp_q = ~exp_q;
      end
      checks++; if (n_ten != 15 || t_en !== 1'b0) begin failures++; $display("FAIL fair_ten g=%0d cycles=%0d t_en=%b exp 15/0", g, n_ten, t_en); end
      checks++; if (done !== exp_oh) begin failures++; $display("FAIL fair_done g=%0d got=%b exp=%b", g, done, exp_oh); end
      if (g == 4) req = '0;
      step();
      checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin failures++; $display("FAIL fair_idle g=%0d busy=%b gnt=%b", g, busy, gnt); end
      if (g < 4) step();
    end
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    cnt = '0;
    exp_q = 1'b0;
    test_reset();
    test_single_burst();
    test_zero_count();
    test_round_robin();
    test_reset_mid_burst();
    test_fairness_max();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tff_toggle_arbiter.md
# tff_toggle_arbiter

Round-robin controller that shares one T flip-flop among N requesters. Each requester asks for a burst of K toggles. The arbiter grants one requester at a time, drives the shared flop's enable and toggle inputs for exactly K cycles, then signals completion. It sits between client logic and the flip-flop primitive and owns the flop state, exposing q/qb.

## Interface

Parameters:
- N, 4, number of requesters (2..8)
- CNT_W, 4, width of each requested toggle count

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- req  input  N  per-requester request level; hold high until the matching done pulse
- cnt  input  N*CNT_W  toggle count per requester; requester i uses bits [i*CNT_W +: CNT_W]
- gnt  output  N  one-hot grant, held for the whole burst
- busy  output  1  high in BURST and DONE states
- t_en  output  1  enable to the shared flop, high only in BURST
- t  output  1  toggle input to the shared flop, equals t_en
- q  output  1  shared flop state
- qb  output  1  always ~q
- done  output  N  one-cycle completion pulse for the granted requester

## Operation

- States: IDLE, BURST, DONE.
- Internal registers:
  - ptr: round-robin pointer, clog2(N) bits.
  - win: index of the granted requester.
  - rem: remaining toggles, CNT_W bits.
  - q: shared flop state.
- IDLE: if any req is high, select the first asserted index scanning ptr, ptr+1, … mod N. Latch win and rem = cnt[win].
  - If rem ≠ 0, go to BURST.
  - If rem = 0, go straight to DONE. No toggles occur.
  - If no req is high, stay in IDLE.
- BURST: t_en = t = 1. At each edge, q ← ~q and rem ← rem − 1. The edge where rem goes from 1 to 0 moves the FSM to DONE.
- DONE: done[win] = 1 for one cycle. gnt stays asserted. ptr ← (win + 1) mod N. Next state is IDLE.
- gnt = one-hot(win) in BURST and DONE; 0 in IDLE.
- cnt is sampled only at grant. Later changes to cnt are ignored until the next grant.
- If req[win] drops mid-burst, the burst still completes and done still pulses.
- Changes to the req of non-granted requesters have no effect until IDLE.
- q keeps its value between bursts and is never cleared except by reset.
- Reset (rst = 0, asynchronous), including mid-burst:
  - state = IDLE, ptr = 0, win = 0, rem = 0, q = 0.
  - Outputs: gnt = 0, done = 0, busy = 0, t_en = 0, t = 0, q = 0, qb = 1.
  - A burst interrupted by reset produces no done pulse.

## Timing

- All outputs are decoded from registered state; there is no combinational path from req to any output.
- Grant latency: with req sampled high at edge E in IDLE, gnt and busy are high in the cycle after E.
- Burst length: t_en is high for exactly K cycles, where K = latched count. q changes K times, so the final q = q_start XOR (K mod 2).
- done timing: done pulses in cycle K+1 after the grant edge. Then IDLE is entered, and a new grant can occur at the following edge.
- Per-burst cycle count: IDLE→IDLE round trip is K+2 cycles for K > 0, and 2 cycles for K = 0.
- Maximum K = 2^CNT_W − 1 (15 by default). There is no wrap: rem stops at 0.
- Simultaneous requests: exactly one is granted per IDLE decision. A requester that has just been served has the lowest priority next time.

## Test plan

- Reset: hold rst = 0 for 2 cycles with random req/cnt → gnt = 0, done = 0, busy = 0, t_en = 0, q = 0, qb = 1. Deassert rst and keep req = 0 → all outputs stay unchanged.
- Single burst: req = 4'b0001, cnt[0] = 3 → gnt = 0001 in the next cycle; t_en high for 3 cycles; q goes 0→1→0→1; done = 0001 in the 4th cycle after grant; final q = 1.
- Round-robin: req = 4'b0101 held, cnt[0] = 1, cnt[2] = 2 → grant order 0, 2, 0, 2. q toggles 1, 2, 1, 2 times respectively. Each done aligns with its own grant.
- Zero count: req = 4'b1000, cnt[3] = 0 → gnt = 1000 for one cycle with done = 1000 in that same cycle; t_en never rises; q unchanged.
- Reset mid-burst: cnt[1] = 10, assert rst = 0 after 4 toggles → q = 0, gnt = 0 immediately; no done pulse. After release with req[1] still high → new burst of 10 starts, with the grant going to requester 1.
- Fairness and max count: all four req high, every cnt = 15 → grants cycle 0, 1, 2, 3, 0. Each burst is 15 t_en cycles; 17-cycle period per grant.
